// File: rtl/mbscore_mem_stage.sv
// Memory-access stage: forwards ALU results to write-back and performs data-memory
// loads/stores over a req/ack bus, stalling EX while an access is outstanding.
module mbscore_mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [1:0]            ex_wb_sel,
  input  logic [DATA_WIDTH-1:0] ex_alu_out,
  input  logic [DATA_WIDTH-1:0] ex_mem_addr,
  input  logic                  flush,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wb_valid,
  output logic [1:0]            wb_sel,
  output logic [DATA_WIDTH-1:0] wb_alu_out,
  output logic [DATA_WIDTH-1:0] wb_mem_data,
  output logic                  mem_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam int         CW      = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [0:0]            state;
  logic [CW-1:0]         cnt;
  logic                  killed;
  logic [1:0]            cap_sel;
  logic [DATA_WIDTH-1:0] cap_alu;
  logic                  accept;

  assign ex_ready = (state == ST_IDLE);
  assign accept   = ex_valid & ex_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      killed      <= 1'b0;
      cap_sel     <= '0;
      cap_alu     <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_sel      <= '0;
      wb_alu_out  <= '0;
      wb_mem_data <= '0;
      mem_err     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          if (!ex_wb_sel[1]) begin
            wb_valid    <= 1'b1;
            wb_sel      <= ex_wb_sel;
            wb_alu_out  <= ex_alu_out;
            wb_mem_data <= '0;
          end else begin
            state      <= ST_BUSY;
            dmem_req   <= 1'b1;
            dmem_we    <= (ex_wb_sel == 2'd2);
            dmem_addr  <= ex_mem_addr;
            dmem_wdata <= ex_alu_out;
            cap_sel    <= ex_wb_sel;
            cap_alu    <= ex_alu_out;
            cnt        <= '0;
            killed     <= 1'b0;
          end
        end
      end else begin
        // A flush arriving on the completing cycle still kills the write-back.
        if (dmem_ack) begin
          state       <= ST_IDLE;
          dmem_req    <= 1'b0;
          wb_valid    <= ~(killed | flush);
          wb_sel      <= cap_sel;
          wb_alu_out  <= cap_alu;
          wb_mem_data <= (cap_sel == 2'd3) ? dmem_rdata : '0;
        end else if (cnt == CNT_LAST) begin
          state       <= ST_IDLE;
          dmem_req    <= 1'b0;
          mem_err     <= 1'b1;
          wb_valid    <= ~(killed | flush);
          wb_sel      <= '0;
          wb_alu_out  <= cap_alu;
          wb_mem_data <= '0;
        end else begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          killed <= killed | flush;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbscore_mem_stage.sv
// Self-checking bench for mbscore_mem_stage: directed scenarios plus randomized
// operations with randomized bus latency and flush, checked cycle by cycle.
module tb_mbscore_mem_stage;
  localparam int DW = 32;
  localparam int TO = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid, ex_ready, flush;
  logic [1:0]    ex_wb_sel;
  logic [DW-1:0] ex_alu_out, ex_mem_addr;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          wb_valid, mem_err;
  logic [1:0]    wb_sel;
  logic [DW-1:0] wb_alu_out, wb_mem_data;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mbscore_mem_stage #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_wb_sel(ex_wb_sel), .ex_alu_out(ex_alu_out), .ex_mem_addr(ex_mem_addr),
    .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_alu_out(wb_alu_out),
    .wb_mem_data(wb_mem_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_quiet(input string tag);
    check_eq({tag, "_ready"}, ex_ready, 1);
    check_eq({tag, "_req"}, dmem_req, 0);
    check_eq({tag, "_wbv"}, wb_valid, 0);
    check_eq({tag, "_err"}, mem_err, 0);
  endtask

  // One operation. delay = BUSY cycle index at which ack is given (>= TO: never).
  // flush_cyc = BUSY cycle index at which flush is pulsed (negative: none).
  task automatic do_op(input logic [1:0] sel, input logic [DW-1:0] alu,
                       input logic [DW-1:0] addr, input int delay, input int flush_cyc);
    int n_busy;
    bit acked, killed;
    logic [DW-1:0] rdata;
    check_eq("start_ready", ex_ready, 1);
    ex_valid = 1'b1; ex_wb_sel = sel; ex_alu_out = alu; ex_mem_addr = addr; flush = 1'b0;
    step();
    ex_valid = 1'b0;
    if (sel < 2) begin
      check_eq("alu_wbv", wb_valid, 1);
      check_eq("alu_sel", wb_sel, sel);
      check_eq("alu_val", wb_alu_out, alu);
      check_eq("alu_mdata", wb_mem_data, 0);
      check_eq("alu_ready", ex_ready, 1);
      check_eq("alu_req", dmem_req, 0);
      return;
    end
    acked  = (delay < TO);
    n_busy = acked ? delay + 1 : TO;
    killed = (flush_cyc >= 0) && (flush_cyc < n_busy);
    rdata  = $urandom;
    for (int k = 0; k < n_busy; k++) begin
      check_eq("busy_req", dmem_req, 1);
      check_eq("busy_we", dmem_we, (sel == 2'd2));
      check_eq("busy_addr", dmem_addr, addr);
      check_eq("busy_wdata", dmem_wdata, alu);
      check_eq("busy_ready", ex_ready, 0);
      check_eq("busy_wbv", wb_valid, 0);
      dmem_ack   = (k == delay);
      dmem_rdata = (k == delay) ? rdata : DW'($urandom);
      flush      = (k == flush_cyc);
      step();
    end
    dmem_ack = 1'b0; flush = 1'b0;
    check_eq("done_req", dmem_req, 0);
    check_eq("done_ready", ex_ready, 1);
    check_eq("done_err", mem_err, !acked);
    check_eq("done_wbv", wb_valid, !killed);
    if (!killed) begin
      check_eq("done_sel", wb_sel, acked ? sel : 2'd0);
      check_eq("done_mdata", wb_mem_data, (acked && sel == 2'd3) ? rdata : '0);
      if (acked) check_eq("done_alu", wb_alu_out, alu);
    end
    step();
    check_eq("post_wbv", wb_valid, 0);
    check_eq("post_err", mem_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_wb_sel = '0; ex_alu_out = '0; ex_mem_addr = '0;
    flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    #12;
    check_idle_quiet("reset");
    check_eq("reset_we", dmem_we, 0);
    check_eq("reset_sel", wb_sel, 0);
    check_eq("reset_alu", wb_alu_out, 0);
    check_eq("reset_mdata", wb_mem_data, 0);
    check_eq("reset_addr", dmem_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // ALU ops, including three back-to-back
    do_op(2'd1, 32'h0000_00AA, 32'h0, 0, -1);
    do_op(2'd1, 32'h1, 32'h0, 0, -1);
    do_op(2'd0, 32'h2, 32'h0, 0, -1);
    do_op(2'd1, 32'h3, 32'h0, 0, -1);
    step();
    check_idle_quiet("alu_gap");

    // load with ack two cycles after req, store with ack in first BUSY cycle
    do_op(2'd3, 32'h5, 32'h100, 2, -1);
    do_op(2'd2, 32'h1234, 32'h40, 0, -1);
    // ack on the final allowed cycle beats timeout
    do_op(2'd3, 32'h7, 32'h80, TO - 1, -1);
    // timeout, then a late ack is ignored
    do_op(2'd3, 32'h9, 32'h200, TO + 5, -1);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_ack = 1'b0;
    check_idle_quiet("late_ack");
    // flush during BUSY load, and flush in the completing cycle
    do_op(2'd3, 32'hB, 32'h300, 3, 1);
    do_op(2'd2, 32'hC, 32'h304, 2, 2);
    // flush during an access that times out: error still reported
    do_op(2'd3, 32'hD, 32'h308, TO + 1, 0);

    // flush together with ex_valid blocks the accept
    ex_valid = 1'b1; ex_wb_sel = 2'd1; ex_alu_out = 32'hEE; flush = 1'b1;
    step();
    ex_valid = 1'b0; flush = 1'b0;
    check_idle_quiet("flush_accept");
    ex_valid = 1'b1; ex_wb_sel = 2'd3; ex_mem_addr = 32'h10; flush = 1'b1;
    step();
    ex_valid = 1'b0; flush = 1'b0;
    check_idle_quiet("flush_accept_ld");

    // asynchronous reset in the middle of an access
    ex_valid = 1'b1; ex_wb_sel = 2'd3; ex_alu_out = 32'h44; ex_mem_addr = 32'h500;
    step();
    ex_valid = 1'b0;
    check_eq("rst_pre_req", dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_quiet("rst_mid");
    check_eq("rst_mid_addr", dmem_addr, 0);
    check_eq("rst_mid_alu", wb_alu_out, 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    check_idle_quiet("rst_release");

    // randomized operations
    for (int i = 0; i < 60; i++) begin
      logic [1:0] s;
      int d, f;
      s = 2'($urandom_range(0, 3));
      d = $urandom_range(0, TO + 2);
      f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO)) : -1;
      do_op(s, DW'($urandom), DW'($urandom), d, f);
      if ($urandom_range(0, 2) == 0) begin
        step();
        check_idle_quiet("rand_gap");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
